nxn_tic_tac_toe: RTL
====================

# nxn_tic_tac_toe

- Parametrised successor to the 3×3 tic-tac-toe game controller.
- Holds an N×N board for a player and a computer, each with a move-request input.
- Enforces alternating turns and rejects illegal moves with a flag.
- Detects a K-in-a-row win or a draw, using a fixed-latency sequential line check around the last move.
- Sits between the position-entry logic and the board LED/display drivers.

## Interface

Parameters:
- N, 3, board dimension, legal range 3..8
- K, 3, win length, legal range 3..N
- PLAYER_FIRST, 1, 1 = player moves first, 0 = computer moves first
- PW (localparam), $clog2(N*N), width of position index
- CW (localparam), $clog2(N*N+1), width of move counter

Ports:
- clock  in  1  system clock; all state changes on its rising edge
- reset  in  1  asynchronous, active-low reset
- play  in  1  player move request, level input, edge-detected internally
- pc  in  1  computer move request, level input, edge-detected internally
- player_position  in  PW  player cell index, row-major, index = row*N + col
- computer_position  in  PW  computer cell index, row-major
- board  out  2*N*N  cell i is at [2i+1:2i]
  - 00 = empty, 01 = player, 10 = computer
- who  out  2  00 = in progress, 01 = player win, 10 = computer win, 11 = draw
- illegal  out  1  one-cycle pulse when a request is rejected
- busy  out  1  high while the win check runs
- move_count  out  CW  number of cells filled

## Operation

- Request edge: each request is registered (play_q, pc_q; reset value 0). A request is `play & ~play_q`, and likewise for pc.
  - A level held high produces exactly one request.
  - A level held high through reset release counts as an edge on the first clock.
- FSM states: TURN_P, TURN_C, CHECK, DONE. Reset state is TURN_P if PLAYER_FIRST=1, else TURN_C.
- TURN_P / TURN_C: a request from the side to move is accepted when its position is < N*N and the cell is empty. On acceptance:
  - the cell is written with the mover's code;
  - move_count is incremented;
  - the position and mover are latched;
  - the FSM goes to CHECK with dir=0.
- CHECK: one direction per cycle.
  - dir 0 = row, 1 = column, 2 = main diagonal (+N+1), 3 = anti-diagonal (+N-1).
  - Each cycle counts consecutive mover cells through the latched cell, up to K-1 steps each way.
  - Counting stops at a mismatch or at a board edge. Column bounds are computed from row/col, never from index arithmetic alone, so there is no row wrap.
  - A run of K or more sets the internal win flag.
  - After dir 3:
    - win → DONE, who = mover code;
    - else if move_count == N*N → DONE, who = 11;
    - else → turn of the other side.
- DONE: board, who and move_count are held until reset.
- Rejections: a request edge produces illegal=1 for exactly one cycle, with no state change, when any of these holds:
  - it comes from the side not on turn;
  - its position is ≥ N*N;
  - the target cell is occupied;
  - the FSM is in CHECK or DONE.
- Simultaneous play and pc edges: the request of the side on turn is evaluated normally; the other sets illegal. illegal is a single pulse even if both requests are rejected.

## Timing

- Edge E0 is the edge that samples an accepted request.
  - At E0: the board cell and move_count update, and busy rises.
  - Edges E1..E4 evaluate dir 0..3.
  - At E4: busy falls and who/turn update.
  - The earliest next accepted request is sampled at E5.
- Move-to-result latency is 4 cycles, fixed regardless of win or early match.
- illegal is asserted in the cycle after the rejected request edge is sampled, and cleared one cycle later.
- Reset (asynchronous, any state including mid-CHECK) immediately sets:
  - board=0, who=00, illegal=0, busy=0, move_count=0;
  - edge registers=0;
  - FSM to the start state.

## Test plan

- N=3, K=3, PLAYER_FIRST=1: P0, C4, P1, C8, P2 → 4 cycles after the last accept: who=01, board[5:0]=010101, move_count=5, busy low. A following pc edge → illegal pulse, board unchanged.
- Occupied/out-of-range/wrong turn: pc edge at start → illegal, state stays TURN_P. Then P0, then C at 0 → illegal, still TURN_C. Then C at 9 → illegal. Then C at 4 → accepted.
- Held level: play held high 5 cycles at position 3 → exactly one move, move_count=1. An edge arriving while busy=1 → illegal.
- Draw: P0 C1 P2 C4 P3 C5 P7 C6 P8 → who=11, move_count=9, no illegal pulses.
- N=5, K=4: P0 C1 P6 C2 P12 C3 P18 → who=01 (diagonal). Separate game, P3 C10 P4 C11 P5 C15 P6 → who=00, no row wrap.
- Reset asserted low while busy=1 → board=0, who=00, busy=0, move_count=0 with no clock edge. After release, the first player move is accepted normally.

Source files
------------

// File: rtl/nxn_tic_tac_toe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : nxn_tic_tac_toe                                               |
// | Purpose  : N x N tic-tac-toe controller for a player and a computer.     |
// |            Alternates turns, rejects illegal requests with a one-cycle   |
// |            pulse, and checks for K-in-a-row through the last move, one   |
// |            direction per cycle, so the result always arrives four cycles |
// |            after an accepted move.                                       |
// | Ports    : clock             - system clock, rising edge                 |
// |            reset             - asynchronous, active-low reset            |
// |            play / pc         - move requests (level, edge-detected)      |
// |            player_position   - player cell index, row*N + col            |
// |            computer_position - computer cell index, row*N + col          |
// |            board             - 2 bits per cell: 00 empty, 01 P, 10 C     |
// |            who               - 00 running, 01 P win, 10 C win, 11 draw   |
// |            illegal           - one-cycle pulse on a rejected request     |
// |            busy              - high while the line check runs            |
// |            move_count        - number of filled cells                    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module nxn_tic_tac_toe #(
   parameter int N            = 3,
   parameter int K            = 3,
   parameter bit PLAYER_FIRST = 1'b1,
   localparam int PW          = $clog2(N*N),
   localparam int CW          = $clog2(N*N+1)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              play,
   input  logic              pc,
   input  logic [PW-1:0]     player_position,
   input  logic [PW-1:0]     computer_position,
   output logic [2*N*N-1:0]  board,
   output logic [1:0]        who,
   output logic              illegal,
   output logic              busy,
   output logic [CW-1:0]     move_count
);

   localparam int         CELLS     = N*N;
   localparam logic [1:0] CODE_P    = 2'b01;
   localparam logic [1:0] CODE_C    = 2'b10;
   localparam logic [1:0] CODE_DRAW = 2'b11;

   typedef enum logic [1:0] {
      TURN_P = 2'd0,
      TURN_C = 2'd1,
      CHECK  = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam state_t START_STATE = PLAYER_FIRST ? TURN_P : TURN_C;

   // Read one cell; indices beyond the board read as occupied so that an
   // out-of-range request falls out of the same "cell must be empty" test.
   function automatic logic [1:0] cell_at(input logic [2*N*N-1:0] b, input int idx);
      logic [1:0] c;
      c = 2'b11;
      for (int i = 0; i < CELLS; i++) begin
         if (i == idx) c = b[2*i +: 2];
      end
      return c;
   endfunction

   // Return the board with one cell replaced by code.
   function automatic logic [2*N*N-1:0] set_cell(input logic [2*N*N-1:0] b, input int idx,
                                                input logic [1:0] code);
      logic [2*N*N-1:0] r;
      r = b;
      for (int i = 0; i < CELLS; i++) begin
         if (i == idx) r[2*i +: 2] = code;
      end
      return r;
   endfunction

   // Run length of mover cells through pos along one direction. Row and
   // column are tracked separately so a step off the right edge never wraps
   // onto the next row.
   function automatic logic line_win(input logic [2*N*N-1:0] b, input int pos,
                                     input logic [1:0] mover, input logic [1:0] dir);
      int   r0, c0, dr, dc, rr, cc, run;
      logic go_f, go_b;
      r0 = pos / N;
      c0 = pos % N;
      case (dir)
         2'd0:    begin dr = 0; dc = 1;  end
         2'd1:    begin dr = 1; dc = 0;  end
         2'd2:    begin dr = 1; dc = 1;  end
         default: begin dr = 1; dc = -1; end
      endcase
      run  = 1;
      go_f = 1'b1;
      go_b = 1'b1;
      for (int s = 1; s < K; s++) begin
         rr = r0 + s*dr;
         cc = c0 + s*dc;
         if (go_f && rr >= 0 && rr < N && cc >= 0 && cc < N &&
             cell_at(b, rr*N + cc) == mover) begin
            run = run + 1;
         end else begin
            go_f = 1'b0;
         end
         rr = r0 - s*dr;
         cc = c0 - s*dc;
         if (go_b && rr >= 0 && rr < N && cc >= 0 && cc < N &&
             cell_at(b, rr*N + cc) == mover) begin
            run = run + 1;
         end else begin
            go_b = 1'b0;
         end
      end
      return (run >= K);
   endfunction

   state_t            state_q, state_d;
   logic [2*N*N-1:0]  board_q, board_d;
   logic [1:0]        who_q, who_d;
   logic              illegal_q, illegal_d;
   logic [CW-1:0]     move_count_q, move_count_d;
   logic [PW-1:0]     pos_q, pos_d;
   logic [1:0]        mover_q, mover_d;
   logic [1:0]        dir_q, dir_d;
   logic              win_q, win_d;
   logic              play_q, pc_q;

   logic              req_p, req_c;
   logic              p_ok, c_ok;
   logic              line_hit;

   assign req_p    = play & ~play_q;
   assign req_c    = pc & ~pc_q;
   assign p_ok     = (cell_at(board_q, int'(player_position)) == 2'b00);
   assign c_ok     = (cell_at(board_q, int'(computer_position)) == 2'b00);
   assign line_hit = line_win(board_q, int'(pos_q), mover_q, dir_q);

   always_comb begin
      state_d      = state_q;
      board_d      = board_q;
      who_d        = who_q;
      illegal_d    = 1'b0;
      move_count_d = move_count_q;
      pos_d        = pos_q;
      mover_d      = mover_q;
      dir_d        = dir_q;
      win_d        = win_q;

      case (state_q)
         TURN_P: begin
            if (req_c) illegal_d = 1'b1;
            if (req_p) begin
               if (p_ok) begin
                  board_d      = set_cell(board_q, int'(player_position), CODE_P);
                  move_count_d = move_count_q + CW'(1);
                  pos_d        = player_position;
                  mover_d      = CODE_P;
                  dir_d        = 2'd0;
                  win_d        = 1'b0;
                  state_d      = CHECK;
               end else begin
                  illegal_d = 1'b1;
               end
            end
         end

         TURN_C: begin
            if (req_p) illegal_d = 1'b1;
            if (req_c) begin
               if (c_ok) begin
                  board_d      = set_cell(board_q, int'(computer_position), CODE_C);
                  move_count_d = move_count_q + CW'(1);
                  pos_d        = computer_position;
                  mover_d      = CODE_C;
                  dir_d        = 2'd0;
                  win_d        = 1'b0;
                  state_d      = CHECK;
               end else begin
                  illegal_d = 1'b1;
               end
            end
         end

         CHECK: begin
            if (req_p | req_c) illegal_d = 1'b1;
            win_d = win_q | line_hit;
            dir_d = dir_q + 2'd1;
            // All four directions always run, so the result latency is fixed.
            if (dir_q == 2'd3) begin
               if (win_q | line_hit) begin
                  state_d = DONE;
                  who_d   = mover_q;
               end else if (move_count_q == CW'(CELLS)) begin
                  state_d = DONE;
                  who_d   = CODE_DRAW;
               end else begin
                  state_d = (mover_q == CODE_P) ? TURN_C : TURN_P;
               end
            end
         end

         default: begin
            if (req_p | req_c) illegal_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= START_STATE;
         board_q      <= '0;
         who_q        <= 2'b00;
         illegal_q    <= 1'b0;
         move_count_q <= '0;
         pos_q        <= '0;
         mover_q      <= 2'b00;
         dir_q        <= 2'd0;
         win_q        <= 1'b0;
         play_q       <= 1'b0;
         pc_q         <= 1'b0;
      end else begin
         state_q      <= state_d;
         board_q      <= board_d;
         who_q        <= who_d;
         illegal_q    <= illegal_d;
         move_count_q <= move_count_d;
         pos_q        <= pos_d;
         mover_q      <= mover_d;
         dir_q        <= dir_d;
         win_q        <= win_d;
         play_q       <= play;
         pc_q         <= pc;
      end
   end

   assign board      = board_q;
   assign who        = who_q;
   assign illegal    = illegal_q;
   assign busy       = (state_q == CHECK);
   assign move_count = move_count_q;

endmodule
`default_nettype wire
